// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register map, STATUS layout,
// default base address and the STATUS word packer.
package mmio_pkg;

  localparam logic [11:0] MMIO_BASE_DEFAULT = 12'hF00;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_RXDATA = 2'd2,
    REG_CYCLES = 2'd3
  } mmio_reg_e;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_VALID = 2;
  localparam int STAT_TX_OVF   = 3;
  localparam int STAT_RX_OVR   = 4;

  function automatic logic [31:0] status_word(
    input logic tx_empty,
    input logic tx_full,
    input logic rx_valid,
    input logic tx_ovf,
    input logic rx_ovr
  );
    logic [31:0] w;
    w                = 32'h0000_0000;
    w[STAT_TX_EMPTY] = tx_empty;
    w[STAT_TX_FULL]  = tx_full;
    w[STAT_RX_VALID] = rx_valid;
    w[STAT_TX_OVF]   = tx_ovf;
    w[STAT_RX_OVR]   = rx_ovr;
    return w;
  endfunction

endpackage

// File: rtl/mmio_txfifo.sv
// Byte-wide synchronous TX FIFO; head byte reads as zero while empty so the
// transmit data output is well defined out of reset.
module mmio_txfifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == DEPTH_C);
  assign count = count_r;

  // Qualify push/pop; a push into a full FIFO only lands when the head leaves.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (empty) begin
      dout = 8'h00;
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care outside the occupied window.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Four-register MMIO block sitting beside the data syncram: TX FIFO, STATUS,
// RX holding register and a free-running cycle counter, with 1-cycle reads.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [11:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_mmio,
  output logic        mmio_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_strobe
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

  logic [11:0]   offset_s;
  logic          in_range_s;
  mmio_reg_e     reg_sel_s;
  logic          tx_push_s;
  logic          tx_pop_s;
  logic          tx_accept_s;
  logic          tx_drop_s;
  logic          stat_wr_s;
  logic          rx_rd_s;
  logic          cyc_wr_s;
  logic          tx_full_s;
  logic          tx_empty_s;
  logic [CW-1:0] tx_count_s;
  logic [31:0]   rd_data_s;

  logic [7:0]    rx_hold_r;
  logic          rx_valid_r;
  logic          tx_ovf_r;
  logic          rx_ovr_r;
  logic [31:0]   cycles_r;

  // Unsigned wrap of the subtraction makes addresses below the base fall out of range.
  assign offset_s   = address_dmem - MMIO_BASE;
  assign in_range_s = (offset_s[11:2] == 10'd0);
  assign reg_sel_s  = mmio_reg_e'(offset_s[1:0]);

  assign tx_pop_s    = tx_valid && tx_ready;
  assign tx_accept_s = tx_push_s && ((tx_count_s < DEPTH_C) || tx_pop_s);
  assign tx_drop_s   = tx_push_s && !tx_accept_s;
  assign tx_valid    = !tx_empty_s;

  mmio_txfifo #(
    .DEPTH (TX_DEPTH)
  ) u_txfifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_accept_s),
    .pop   (tx_pop_s),
    .din   (data[7:0]),
    .dout  (tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  // Address decode into per-register strobes; every in-range access is also a read.
  always_comb begin
    tx_push_s = 1'b0;
    stat_wr_s = 1'b0;
    rx_rd_s   = 1'b0;
    cyc_wr_s  = 1'b0;
    if (in_range_s) begin
      case (reg_sel_s)
        REG_TXDATA: tx_push_s = wren;
        REG_STATUS: stat_wr_s = wren;
        REG_RXDATA: rx_rd_s   = 1'b1;
        REG_CYCLES: cyc_wr_s  = wren;
        default:    tx_push_s = 1'b0;
      endcase
    end else begin
      tx_push_s = 1'b0;
      stat_wr_s = 1'b0;
      rx_rd_s   = 1'b0;
      cyc_wr_s  = 1'b0;
    end
  end

  // Read mux over pre-edge register values.
  always_comb begin
    case (reg_sel_s)
      REG_TXDATA: rd_data_s = 32'h0000_0000;
      REG_STATUS: rd_data_s = status_word(tx_empty_s, tx_full_s, rx_valid_r,
                                          tx_ovf_r, rx_ovr_r);
      REG_RXDATA: rd_data_s = {rx_valid_r, 23'd0, rx_hold_r};
      REG_CYCLES: rd_data_s = cycles_r;
      default:    rd_data_s = 32'h0000_0000;
    endcase
  end

  // Registered read response, zero when the address is not ours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_mmio   <= 32'h0000_0000;
      mmio_hit <= 1'b0;
    end else begin
      mmio_hit <= in_range_s;
      q_mmio   <= in_range_s ? rd_data_s : 32'h0000_0000;
    end
  end

  // A load stores data+1 so the written value reads back already advanced one tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles_r <= 32'h0000_0000;
    end else if (cyc_wr_s) begin
      cycles_r <= data + 32'd1;
    end else begin
      cycles_r <= cycles_r + 32'd1;
    end
  end

  // RX capture: a new byte wins over a same-cycle read, so rx_valid stays set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_hold_r  <= 8'h00;
      rx_valid_r <= 1'b0;
    end else if (rx_strobe) begin
      rx_hold_r  <= rx_byte;
      rx_valid_r <= 1'b1;
    end else if (rx_rd_s) begin
      rx_valid_r <= 1'b0;
    end
  end

  // Sticky error flags; a fresh error event takes priority over a software clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_ovf_r <= 1'b0;
      rx_ovr_r <= 1'b0;
    end else begin
      if (tx_drop_s) begin
        tx_ovf_r <= 1'b1;
      end else if (stat_wr_s && data[STAT_TX_OVF]) begin
        tx_ovf_r <= 1'b0;
      end
      if (rx_strobe && rx_valid_r && !rx_rd_s) begin
        rx_ovr_r <= 1'b1;
      end else if (stat_wr_s && data[STAT_RX_OVR]) begin
        rx_ovr_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with a queue-based reference model
// compared every cycle, plus literal expectations on key transactions.
module tb_mmio_responder;

  localparam logic [11:0] BASE  = 12'hF00;
  localparam int          DEPTH = 4;
  localparam logic [11:0] IDLE  = 12'h000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = 12'h000;
  logic [31:0] data = 32'h0;
  logic        wren = 1'b0;
  logic [31:0] q_mmio;
  logic        mmio_hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_strobe = 1'b0;

  always #5 clock = ~clock;

  mmio_responder #(
    .MMIO_BASE (BASE),
    .TX_DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_mmio       (q_mmio),
    .mmio_hit     (mmio_hit),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_byte      (rx_byte),
    .rx_strobe    (rx_strobe)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [7:0]  m_txq[$];
  logic        m_tx_ovf;
  logic        m_rx_ovr;
  logic        m_rx_valid;
  logic [7:0]  m_rx_hold;
  logic [31:0] m_cyc;
  logic        m_hit;
  logic [31:0] m_q;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_tx_ovf   = 1'b0;
    m_rx_ovr   = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_hold  = 8'h00;
    m_cyc      = 32'h0;
    m_hit      = 1'b0;
    m_q        = 32'h0;
  endtask

  // One bus cycle: drive, let the edge happen, advance the model, return at negedge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, input logic stb, input logic [7:0] b);
    logic [11:0] off;
    bit          inr;
    bit          pop;
    bit          rd;
    int          sz;
    address_dmem = a;
    data         = d;
    wren         = we;
    tx_ready     = rdy;
    rx_strobe    = stb;
    rx_byte      = b;
    @(posedge clock);
    off = a - BASE;
    inr = (off < 12'd4);
    sz  = m_txq.size();
    pop = (sz > 0) && rdy;
    rd  = inr && (off == 12'd2);
    m_hit = inr;
    m_q   = 32'h0;
    if (inr) begin
      if (off == 12'd1)
        m_q = 32'(m_rx_ovr) * 16 + 32'(m_tx_ovf) * 8 + 32'(m_rx_valid) * 4
            + 32'(sz == DEPTH) * 2 + 32'(sz == 0);
      else if (off == 12'd2)
        m_q = 32'(m_rx_valid) * 32'h8000_0000 + 32'(m_rx_hold);
      else if (off == 12'd3)
        m_q = m_cyc;
    end
    if (pop) void'(m_txq.pop_front());
    if (inr && we && off == 12'd0) begin
      if (sz < DEPTH || pop) m_txq.push_back(d[7:0]);
      else m_tx_ovf = 1'b1;
    end
    if (inr && we && off == 12'd1) begin
      if (d[3]) m_tx_ovf = 1'b0;
      if (d[4]) m_rx_ovr = 1'b0;
    end
    if (stb) begin
      if (m_rx_valid && !rd) m_rx_ovr = 1'b1;
      m_rx_hold  = b;
      m_rx_valid = 1'b1;
    end else if (rd) begin
      m_rx_valid = 1'b0;
    end
    m_cyc = (inr && we && off == 12'd3) ? d + 32'd1 : m_cyc + 32'd1;
    @(negedge clock);
  endtask

  task automatic rd_expect(input string name, input logic [11:0] a, input logic [31:0] exp);
    step(a, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    check32(name, q_mmio, exp);
    check32({name, "_hit"}, {31'd0, mmio_hit}, 32'd1);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check32("mdl_hit", {31'd0, mmio_hit}, {31'd0, m_hit});
      check32("mdl_q", q_mmio, m_q);
      check32("mdl_tx_valid", {31'd0, tx_valid}, {31'd0, m_txq.size() != 0});
      check32("mdl_tx_data", {24'd0, tx_data}, (m_txq.size() != 0) ? {24'd0, m_txq[0]} : 32'h0);
    end
  end

  logic [7:0] drain_exp [3] = '{8'h42, 8'h43, 8'h44};

  initial begin
    #1 reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check32("rst_hit", {31'd0, mmio_hit}, 32'd0);
    check32("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    reset = 1'b1;

    // Reset state
    rd_expect("status_after_reset", BASE + 12'd1, 32'h0000_0001);
    check32("tx_valid_after_reset", {31'd0, tx_valid}, 32'd0);

    // Overfill with consumer stalled
    for (int i = 0; i < 5; i++)
      step(BASE, 32'h41 + 32'(i), 1'b1, 1'b0, 1'b0, 8'h00);
    rd_expect("status_full_ovf", BASE + 12'd1, 32'h0000_000A);
    check32("head_41", {24'd0, tx_data}, 32'h41);
    for (int i = 0; i < 3; i++) begin
      step(IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
      check32("drain_seq", {24'd0, tx_data}, {24'd0, drain_exp[i]});
    end
    step(IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    check32("drained_valid", {31'd0, tx_valid}, 32'd0);
    check32("drained_data", {24'd0, tx_data}, 32'h0);
    step(BASE + 12'd1, 32'h8, 1'b1, 1'b0, 1'b0, 8'h00);
    check32("status_wr_prewrite", q_mmio, 32'h0000_0009);
    rd_expect("status_ovf_cleared", BASE + 12'd1, 32'h0000_0001);

    // Push on full with simultaneous pop
    for (int i = 1; i <= 4; i++)
      step(BASE, 32'h11 * 32'(i), 1'b1, 1'b0, 1'b0, 8'h00);
    step(BASE, 32'h55, 1'b1, 1'b1, 1'b0, 8'h00);
    rd_expect("status_full_no_ovf", BASE + 12'd1, 32'h0000_0002);
    for (int i = 0; i < 3; i++) step(IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    check32("last_is_55", {24'd0, tx_data}, 32'h55);
    step(IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);

    // RX overrun
    step(IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 8'h7E);
    step(IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 8'h7F);
    rd_expect("rxdata_ovr", BASE + 12'd2, 32'h8000_007F);
    rd_expect("status_rx_ovr", BASE + 12'd1, 32'h0000_0011);
    rd_expect("rxdata_second", BASE + 12'd2, 32'h0000_007F);
    step(BASE + 12'd1, 32'h10, 1'b1, 1'b0, 1'b0, 8'h00);
    rd_expect("status_ovr_cleared", BASE + 12'd1, 32'h0000_0001);

    // Strobe coinciding with RXDATA read
    step(IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 8'h10);
    step(BASE + 12'd2, 32'h0, 1'b0, 1'b0, 1'b1, 8'h20);
    check32("rx_same_cycle_old", q_mmio, 32'h8000_0010);
    rd_expect("status_rx_kept", BASE + 12'd1, 32'h0000_0005);
    rd_expect("rxdata_new", BASE + 12'd2, 32'h8000_0020);

    // Cycle counter load and wrap
    step(BASE + 12'd3, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 8'h00);
    step(IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_expect("cycles_wrap", BASE + 12'd3, 32'h0000_0000);
    rd_expect("cycles_after_wrap", BASE + 12'd3, 32'h0000_0001);

    // Out-of-range accesses have no effect
    step(12'h0F4, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    check32("oor_hit", {31'd0, mmio_hit}, 32'd0);
    check32("oor_q", q_mmio, 32'h0);
    step(BASE + 12'd4, 32'h41, 1'b1, 1'b0, 1'b0, 8'h00);
    step(BASE - 12'd1, 32'h18, 1'b1, 1'b0, 1'b0, 8'h00);
    step(BASE + 12'd2, 32'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    rd_expect("status_after_oor", BASE + 12'd1, 32'h0000_0001);

    // Reset mid-burst
    for (int i = 0; i < 3; i++)
      step(BASE, 32'hA1 + 32'(i), 1'b1, 1'b0, 1'b0, 8'h00);
    step(IDLE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check32("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check32("async_rst_tx_data", {24'd0, tx_data}, 32'h0);
    check32("async_rst_hit", {31'd0, mmio_hit}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    tx_ready = 1'b0;
    reset = 1'b1;
    rd_expect("status_after_rerst", BASE + 12'd1, 32'h0000_0001);
    rd_expect("cycles_after_rerst", BASE + 12'd3, 32'h0000_0001);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter MMIO_BASE, default 12'hF00, the word address of the first MMIO register.
REQ-002 SHALL have parameter TX_DEPTH, default 4, the TX FIFO entry count (power of two, at least 2).
REQ-003 SHALL run on one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 address_dmem  in  12  word address from the processor's dmem port.
REQ-007 data  in  32  store data from the processor.
REQ-008 wren  in  1  store enable from the processor.
REQ-009 q_mmio  out  32  read data, registered.
REQ-010 mmio_hit  out  1  registered; high when q_mmio is valid and SHALL replace q_dmem.
REQ-011 tx_data  out  8  head byte of the TX FIFO.
REQ-012 tx_valid  out  1  TX FIFO is not empty.
REQ-013 tx_ready  in  1  the consumer accepts tx_data this cycle when tx_valid is also high.
REQ-014 rx_byte  in  8  incoming byte.
REQ-015 rx_strobe  in  1  one-cycle pulse; rx_byte is valid.

Function
REQ-016 Decode: offset = address_dmem - MMIO_BASE. The access is in range when 0 <= offset <= 3; all other addresses SHALL be ignored and SHALL have no side effects.
REQ-017 Read latency SHALL be one cycle, the same as the syncram. Cycle N sends the address; at cycle N+1 q_mmio holds the data and mmio_hit = 1. Outside the window, mmio_hit = 0 and q_mmio = 0.
REQ-018 Offset 0, TXDATA: a write pushes data[7:0]. A read returns 0.
REQ-019 A TXDATA write SHALL be accepted when count < TX_DEPTH, or when count == TX_DEPTH and the head pops in the same cycle.
REQ-020 A TXDATA write that is not accepted SHALL be dropped and SHALL set the sticky bit tx_ovf.
REQ-021 Offset 1, STATUS read: {27'b0, rx_ovr, tx_ovf, rx_valid, tx_full, tx_empty}, with tx_empty at bit 0.
REQ-022 A STATUS write SHALL clear tx_ovf when data[3] = 1 and clear rx_ovr when data[4] = 1. Other bits are ignored.
REQ-023 Offset 2, RXDATA read: returns {rx_valid, 23'b0, rx_hold[7:0]} and clears rx_valid. A write is ignored.
REQ-024 Offset 3, CYCLES: free-running 32-bit counter, incremented every cycle, wrapping 0xFFFFFFFF -> 0.
REQ-025 A CYCLES write SHALL load data, and the counter SHALL read data+1 on the next cycle. A read returns the value before the increment of that edge.
REQ-026 TX pop SHALL occur when tx_valid && tx_ready. Pointers SHALL wrap modulo TX_DEPTH.
REQ-027 Push on an empty FIFO SHALL raise tx_valid on the next cycle. There is no bypass.
REQ-028 rx_strobe SHALL load rx_hold and set rx_valid. If rx_valid is already 1 and is not being cleared this cycle, rx_ovr SHALL also be set, and the new byte overwrites.
REQ-029 When rx_strobe and an RXDATA read occur in the same cycle, the read SHALL return the old value. The new byte SHALL be captured and rx_valid SHALL stay 1, with no overrun.
REQ-030 wren during a read-only cycle: a write to any in-range offset SHALL also produce a read response, which is the pre-write value.

Reset
REQ-031 While reset = 0, the following SHALL be asynchronously cleared: FIFO pointers and count, rx_hold, rx_valid, tx_ovf, rx_ovr, the CYCLES counter, q_mmio and mmio_hit.
REQ-032 Reset SHALL produce the outputs tx_valid = 0 and tx_data = 0.
REQ-033 Reset asserted mid-transfer SHALL discard FIFO contents; no partial pop is permitted.
REQ-034 The first rising edge after reset deasserts SHALL behave as a normal cycle.

Structure
REQ-035 Register offsets, STATUS bit positions and default MMIO_BASE SHALL reside in shared package mmio_pkg.
REQ-036 The TX FIFO SHALL be the sub-module mmio_txfifo: synchronous, with push/pop/full/empty/count and asynchronous active-low reset.
REQ-037 The remaining logic (decode, STATUS/RX/CYCLES registers, read mux) SHALL be in mmio_responder.

Verification
REQ-038 After reset, read STATUS -> q_mmio = 0x00000001 and mmio_hit = 1 one cycle later; tx_valid = 0.
REQ-039 Write 0x41, 0x42, 0x43, 0x44, 0x45 to TXDATA with tx_ready = 0 -> STATUS = 0x0000000A (full, ovf). Then hold tx_ready = 1 -> tx_data sequence 0x41..0x44, then tx_valid = 0.
REQ-040 With the FIFO full, a TXDATA write of 0x55 together with tx_ready = 1 -> accepted; tx_ovf unchanged; 0x55 appears last.
REQ-041 rx_strobe with 0x7E, then rx_strobe with 0x7F -> RXDATA = 0x8000007F and STATUS bit 4 = 1. A second RXDATA read returns 0x0000007F.
REQ-042 Write 0xFFFFFFFE to CYCLES, then read two cycles later -> 0x00000000 (wrap).
REQ-043 Read address 0x0F4 -> mmio_hit = 0 and q_mmio = 0; no state change.
REQ-044 Assert reset mid-burst with 3 bytes queued -> tx_valid = 0 immediately, without waiting for a clock edge; after release, STATUS = 0x00000001.
